// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage sequencer (fetch_ctrl).
package fetch_ctrl_pkg;

    localparam int PC_W        = 8;
    localparam int FLUSH_CNT_W = 3;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } fc_state_t;

    typedef enum logic [2:0] {
        ACT_NONE   = 3'd0,
        ACT_BRANCH = 3'd1,
        ACT_JUMP   = 3'd2,
        ACT_HALT   = 3'd3,
        ACT_STALL  = 3'd4
    } arb_act_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_ctrl_redirect_arb.sv
// Priority pick among branch, jump, halt and stall requests for the RUN state.
module redirect_arb
    import fetch_ctrl_pkg::*;
(
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp_req,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            halt_req,
    input  logic            stall_req,
    output arb_act_t        act,
    output logic [PC_W-1:0] target
);

    // Older instruction (execute-stage branch) wins over the younger jump.
    always_comb begin
        act    = ACT_NONE;
        target = br_target;
        if (br_taken) begin
            act    = ACT_BRANCH;
            target = br_target;
        end else if (jmp_req) begin
            act    = ACT_JUMP;
            target = jmp_target;
        end else if (halt_req) begin
            act    = ACT_HALT;
        end else if (stall_req) begin
            act    = ACT_STALL;
        end else begin
            act    = ACT_NONE;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC write port, redirect flush, stall hold and halt/resume.
// Optional perf counters (redirectCnt, stallCnt) enabled by defining FETCH_CTRL_PERF_EN.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC     = 8'h00,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallReq,
    input  logic            brTaken,
    input  logic [PC_W-1:0] brTarget,
    input  logic            jmpReq,
    input  logic [PC_W-1:0] jmpTarget,
    input  logic            haltReq,
    input  logic            resume,
    output logic            pcWrEn,
    output logic [PC_W-1:0] newPc,
    output logic            pcHold,
    output logic            flushFD,
    output logic            flushDE,
    output logic            halted
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [15:0]     redirectCnt,
    output logic [15:0]     stallCnt
`endif
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    fc_state_t              state_r, state_s;
    logic [FLUSH_CNT_W-1:0] cnt_r, cnt_s;
    logic [PC_W-1:0]        target_r, target_s;
    logic                   pc_wr_en_s, flush_fd_s, flush_de_s, halted_s;
    logic [PC_W-1:0]        new_pc_s;
    logic                   redirect_s;
    arb_act_t               act_s;
    logic [PC_W-1:0]        arb_target_s;

    redirect_arb u_arb (
        .br_taken  (brTaken),
        .br_target (brTarget),
        .jmp_req   (jmpReq),
        .jmp_target(jmpTarget),
        .halt_req  (haltReq),
        .stall_req (stallReq),
        .act       (act_s),
        .target    (arb_target_s)
    );

    // A redirect in a stall cycle wins, so the hold drops that cycle.
    assign pcHold = ((state_r == RUN) && stallReq && !brTaken && !jmpReq) || (state_r == HALT);

    // Next state plus the values the registered outputs take for the next cycle.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        target_s   = target_r;
        pc_wr_en_s = 1'b0;
        new_pc_s   = newPc;
        flush_fd_s = 1'b0;
        flush_de_s = 1'b0;
        halted_s   = 1'b0;
        redirect_s = 1'b0;
        case (state_r)
            BOOT: begin
                state_s = RUN;
            end
            RUN: begin
                case (act_s)
                    ACT_BRANCH, ACT_JUMP: begin
                        state_s    = FLUSH;
                        target_s   = arb_target_s;
                        cnt_s      = FLUSH_LOAD;
                        pc_wr_en_s = 1'b1;
                        new_pc_s   = arb_target_s;
                        flush_fd_s = 1'b1;
                        flush_de_s = 1'b1;
                        redirect_s = 1'b1;
                    end
                    ACT_HALT: begin
                        state_s  = HALT;
                        halted_s = 1'b1;
                    end
                    default: begin
                        state_s = RUN;
                    end
                endcase
            end
            FLUSH: begin
                if (cnt_r == {FLUSH_CNT_W{1'b0}}) begin
                    state_s = RUN;
                end else begin
                    cnt_s      = cnt_r - {{(FLUSH_CNT_W-1){1'b0}}, 1'b1};
                    flush_fd_s = 1'b1;
                end
            end
            HALT: begin
                if (resume) begin
                    state_s = RUN;
                end else begin
                    halted_s = 1'b1;
                end
            end
            default: begin
                state_s = BOOT;
            end
        endcase
    end

    // State, flush counter, latched target and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= BOOT;
            cnt_r    <= {FLUSH_CNT_W{1'b0}};
            target_r <= {PC_W{1'b0}};
            pcWrEn   <= 1'b1;
            newPc    <= RESET_PC;
            flushFD  <= 1'b0;
            flushDE  <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            target_r <= target_s;
            pcWrEn   <= pc_wr_en_s;
            newPc    <= new_pc_s;
            flushFD  <= flush_fd_s;
            flushDE  <= flush_de_s;
            halted   <= halted_s;
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] redirect_cnt_r;
    logic [15:0] stall_cnt_r;

    // Saturating counts of accepted redirects and held RUN cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt_r <= 16'd0;
            stall_cnt_r    <= 16'd0;
        end else begin
            if (redirect_s) begin
                redirect_cnt_r <= sat_inc16(redirect_cnt_r);
            end
            if ((state_r == RUN) && pcHold) begin
                stall_cnt_r <= sat_inc16(stall_cnt_r);
            end
        end
    end

    assign redirectCnt = redirect_cnt_r;
    assign stallCnt    = stall_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run against a reference model.
module tb_fetch_ctrl;

    localparam int          FC  = 2;
    localparam logic [7:0]  RPC = 8'h00;

    logic       clk, rst, stallReq, brTaken, jmpReq, haltReq, resume;
    logic [7:0] brTarget, jmpTarget, newPc;
    logic       pcWrEn, pcHold, flushFD, flushDE, halted;
`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] redirectCnt, stallCnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit         m_boot, m_in_halt, m_wr, m_fd, m_de, m_halted, m_hold;
    int         m_flush_rem;
    logic [7:0] m_pc;
    int         m_redirects, m_stalls;

    fetch_ctrl #(.RESET_PC(RPC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .stallReq(stallReq), .brTaken(brTaken), .brTarget(brTarget),
        .jmpReq(jmpReq), .jmpTarget(jmpTarget), .haltReq(haltReq), .resume(resume),
        .pcWrEn(pcWrEn), .newPc(newPc), .pcHold(pcHold), .flushFD(flushFD),
        .flushDE(flushDE), .halted(halted)
`ifdef FETCH_CTRL_PERF_EN
        , .redirectCnt(redirectCnt), .stallCnt(stallCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        stallReq = 1'b0; brTaken = 1'b0; jmpReq = 1'b0; haltReq = 1'b0; resume = 1'b0;
        brTarget = 8'h00; jmpTarget = 8'h00;
    endtask

    task automatic model_reset();
        m_boot = 1'b1; m_in_halt = 1'b0; m_flush_rem = 0;
        m_wr = 1'b1; m_pc = RPC; m_fd = 1'b0; m_de = 1'b0; m_halted = 1'b0;
        m_redirects = 0; m_stalls = 0;
    endtask

    function automatic bit model_hold();
        bit running;
        running = !m_boot && !m_in_halt && (m_flush_rem == 0);
        return (running && stallReq && !brTaken && !jmpReq) || m_in_halt;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (m_boot) begin
            m_boot = 1'b0; m_wr = 1'b0;
        end else if (m_in_halt) begin
            m_wr = 1'b0;
            if (resume) begin
                m_in_halt = 1'b0; m_halted = 1'b0;
            end
        end else if (m_flush_rem > 0) begin
            m_flush_rem = m_flush_rem - 1;
            m_wr = 1'b0; m_de = 1'b0; m_fd = (m_flush_rem > 0);
        end else begin
            if (stallReq && !brTaken && !jmpReq) m_stalls = m_stalls + 1;
            if (brTaken || jmpReq) begin
                m_pc = brTaken ? brTarget : jmpTarget;
                m_wr = 1'b1; m_fd = 1'b1; m_de = 1'b1;
                m_flush_rem = FC;
                m_redirects = m_redirects + 1;
            end else if (haltReq) begin
                m_in_halt = 1'b1; m_halted = 1'b1; m_wr = 1'b0;
            end else begin
                m_wr = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_in();
        #2;
        n_checks++; if (pcWrEn !== 1'b1) $display("FAIL rst_wr: got %b want 1", pcWrEn); else n_pass++;
        n_checks++; if (newPc !== 8'h00) $display("FAIL rst_pc: got %h want 00", newPc); else n_pass++;
        n_checks++; if ({pcHold, flushFD, flushDE, halted} !== 4'b0000)
            $display("FAIL rst_flags: got %b want 0000", {pcHold, flushFD, flushDE, halted}); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        stallReq = 1'b1;
        #1;
        n_checks++; if (pcWrEn !== 1'b1 || newPc !== 8'h00) $display("FAIL boot_wr: got %b/%h want 1/00", pcWrEn, newPc); else n_pass++;
        n_checks++; if (pcHold !== 1'b0) $display("FAIL boot_hold: got %b want 0", pcHold); else n_pass++;
        stallReq = 1'b0;
        cyc();
        n_checks++; if (pcWrEn !== 1'b0) $display("FAIL run_wr: got %b want 0", pcWrEn); else n_pass++;
        stallReq = 1'b1;
        #1;
        n_checks++; if (pcHold !== 1'b1) $display("FAIL run_entered: got %b want 1", pcHold); else n_pass++;
        stallReq = 1'b0;
    endtask

    task automatic test_branch();
        brTaken = 1'b1; brTarget = 8'h10;
        cyc();
        brTaken = 1'b0;
        jmpReq = 1'b1; jmpTarget = 8'h55;
        #1;
        n_checks++; if ({pcWrEn, newPc} !== {1'b1, 8'h10}) $display("FAIL br_write: got %b/%h want 1/10", pcWrEn, newPc); else n_pass++;
        n_checks++; if ({flushFD, flushDE} !== 2'b11) $display("FAIL br_flush1: got %b want 11", {flushFD, flushDE}); else n_pass++;
        cyc();
        jmpReq = 1'b0;
        #1;
        n_checks++; if ({pcWrEn, flushFD, flushDE} !== 3'b010) $display("FAIL br_flush2: got %b want 010", {pcWrEn, flushFD, flushDE}); else n_pass++;
        cyc();
        n_checks++; if ({pcWrEn, flushFD, newPc} !== {2'b00, 8'h10}) $display("FAIL br_done: got %b/%b/%h want 0/0/10", pcWrEn, flushFD, newPc); else n_pass++;
    endtask

    task automatic test_same_cycle();
        int pulses;
        brTaken = 1'b1; brTarget = 8'h20; jmpReq = 1'b1; jmpTarget = 8'h30;
        cyc();
        clear_in();
        #1;
        n_checks++; if ({pcWrEn, newPc} !== {1'b1, 8'h20}) $display("FAIL same_pick: got %b/%h want 1/20", pcWrEn, newPc); else n_pass++;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (pcWrEn === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 0 || newPc !== 8'h20) $display("FAIL same_single: got %0d extra pulses pc %h want 0 / 20", pulses, newPc); else n_pass++;
    endtask

    task automatic test_stall();
        int bad;
        bad = 0;
        stallReq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (pcHold !== 1'b1 || pcWrEn !== 1'b0) bad++;
            cyc();
        end
        stallReq = 1'b0;
        #1;
        n_checks++; if (bad != 0) $display("FAIL stall_hold: got %0d bad cycles want 0", bad); else n_pass++;
        n_checks++; if (pcHold !== 1'b0) $display("FAIL stall_release: got %b want 0", pcHold); else n_pass++;
        cyc();
        stallReq = 1'b1;
        cyc();
        jmpReq = 1'b1; jmpTarget = 8'h40;
        #1;
        n_checks++; if (pcHold !== 1'b0) $display("FAIL stall_jmp_hold: got %b want 0", pcHold); else n_pass++;
        cyc();
        jmpReq = 1'b0;
        #1;
        n_checks++; if ({pcWrEn, newPc, pcHold} !== {1'b1, 8'h40, 1'b0}) $display("FAIL stall_jmp_write: got %b/%h/%b want 1/40/0", pcWrEn, newPc, pcHold); else n_pass++;
        stallReq = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_halt();
        haltReq = 1'b1;
        cyc();
        haltReq = 1'b0;
        n_checks++; if ({halted, pcHold} !== 2'b11) $display("FAIL halt_enter: got %b want 11", {halted, pcHold}); else n_pass++;
        jmpReq = 1'b1; jmpTarget = 8'h77; brTaken = 1'b1; brTarget = 8'h66;
        cyc();
        clear_in();
        #1;
        n_checks++; if ({pcWrEn, newPc, halted} !== {1'b0, 8'h40, 1'b1}) $display("FAIL halt_ignore: got %b/%h/%b want 0/40/1", pcWrEn, newPc, halted); else n_pass++;
        resume = 1'b1;
        cyc();
        resume = 1'b0;
        #1;
        n_checks++; if ({halted, pcHold, pcWrEn} !== 3'b000) $display("FAIL resume: got %b want 000", {halted, pcHold, pcWrEn}); else n_pass++;
        resume = 1'b1;
        cyc();
        resume = 1'b0;
        #1;
        n_checks++; if ({halted, pcWrEn, newPc} !== {2'b00, 8'h40}) $display("FAIL resume_run: got %b/%b/%h want 0/0/40", halted, pcWrEn, newPc); else n_pass++;
    endtask

    task automatic test_reset_mid_flush();
        brTaken = 1'b1; brTarget = 8'h99;
        cyc();
        brTaken = 1'b0;
        cyc();
        rst = 1'b1;
        #1;
        n_checks++; if ({pcWrEn, newPc, flushFD, flushDE, halted, pcHold} !== {1'b1, 8'h00, 4'b0000})
            $display("FAIL rst_flush: got %b/%h/%b want 1/00/0000", pcWrEn, newPc, {flushFD, flushDE, halted, pcHold}); else n_pass++;
`ifdef FETCH_CTRL_PERF_EN
        n_checks++; if (redirectCnt !== 16'd0) $display("FAIL rst_perf: got %0d want 0", redirectCnt); else n_pass++;
`endif
        @(negedge clk);
        rst = 1'b0;
        cyc();
        cyc();
        n_checks++; if ({pcWrEn, newPc, flushFD} !== {1'b0, 8'h00, 1'b0}) $display("FAIL rst_drop: got %b/%h/%b want 0/00/0", pcWrEn, newPc, flushFD); else n_pass++;
    endtask

    task automatic test_random();
        bit halt_lvl;
        int errs;
        errs = 0;
        halt_lvl = 1'b0;
        rst = 1'b1;
        clear_in();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(63) == 0);
            brTaken   = ($urandom_range(7) == 0);
            jmpReq    = ($urandom_range(6) == 0);
            brTarget  = 8'($urandom);
            jmpTarget = 8'($urandom);
            stallReq  = ($urandom_range(3) == 0);
            resume    = ($urandom_range(5) == 0);
            if (m_halted || rst) halt_lvl = 1'b0;
            else if (!halt_lvl && $urandom_range(19) == 0) halt_lvl = 1'b1;
            haltReq = halt_lvl;
            if (rst) model_reset();
            #1;
            m_hold = model_hold();
            n_checks++;
            if ({pcWrEn, newPc, pcHold, flushFD, flushDE, halted} !== {m_wr, m_pc, m_hold, m_fd, m_de, m_halted}) begin
                if (errs < 10) $display("FAIL rand_cycle%0d: got %b/%h/%b%b%b%b want %b/%h/%b%b%b%b", i,
                    pcWrEn, newPc, pcHold, flushFD, flushDE, halted, m_wr, m_pc, m_hold, m_fd, m_de, m_halted);
                errs++;
            end else n_pass++;
`ifdef FETCH_CTRL_PERF_EN
            n_checks++;
            if (redirectCnt !== 16'(m_redirects) || stallCnt !== 16'(m_stalls)) begin
                if (errs < 10) $display("FAIL rand_perf%0d: got %0d/%0d want %0d/%0d", i, redirectCnt, stallCnt, m_redirects, m_stalls);
                errs++;
            end else n_pass++;
`endif
            @(posedge clk);
            model_step();
            #1;
        end
        rst = 1'b0;
        clear_in();
    endtask

    initial begin
        test_reset();
        test_branch();
        test_same_cycle();
        test_stall();
        test_halt();
        test_reset_mid_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
